// File: rtl/cpu_pkg.sv
// Shared CPU constants and the reservation-station entry record.
//   TAG_W      physical-register tag width
//   PAY_W      opaque payload width (alu_sig 3 + imm 32 + pc 12)
//   rs_entry_t one scheduler slot: valid, two sources with ready bits,
//              destination tag, payload
package cpu_pkg;
  localparam int TAG_W = 6;
  localparam int PAY_W = 47;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] src1_tag;
    logic             src1_rdy;
    logic [TAG_W-1:0] src2_tag;
    logic             src2_rdy;
    logic [TAG_W-1:0] dst_tag;
    logic [PAY_W-1:0] payload;
  } rs_entry_t;
endpackage

// File: rtl/iss_select.sv
// Lowest-index picker over the eligible vector (combinational).
//   elig   in  DEPTH  one bit per queue entry, set when it can issue
//   found  out 1      at least one bit of elig set
//   idx    out IDX_W  lowest set position (0 when none)
module iss_select #(
  parameter int DEPTH = 8,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0] elig,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    // scan downward so the last hit is the lowest (oldest) index
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/issue_scheduler.sv
// In-order-age reservation station feeding a single ALU.
// Compacting queue (entry 0 oldest), tag wakeup from completion broadcasts,
// oldest-ready selection into a registered valid/ready issue stage.
//   clk, rst            clock, synchronous active-high reset
//   flush               drop every queued and staged instruction
//   disp_*              dispatch request / ready, source tags + ready bits,
//                       destination tag, payload
//   wb_valid, wb_tag    completion broadcast
//   iss_*               staged instruction to the ALU, valid/ready handshake
//   occupancy           valid queue entries, staged slot excluded
module issue_scheduler #(
  parameter int DEPTH = 8,
  parameter int TAG_W = cpu_pkg::TAG_W,
  parameter int PAY_W = cpu_pkg::PAY_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [TAG_W-1:0]           disp_src1_tag,
  input  logic [TAG_W-1:0]           disp_src2_tag,
  input  logic                       disp_src1_rdy,
  input  logic                       disp_src2_rdy,
  input  logic [TAG_W-1:0]           disp_dst_tag,
  input  logic [PAY_W-1:0]           disp_payload,
  input  logic                       wb_valid,
  input  logic [TAG_W-1:0]           wb_tag,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [TAG_W-1:0]           iss_src1_tag,
  output logic [TAG_W-1:0]           iss_src2_tag,
  output logic [TAG_W-1:0]           iss_dst_tag,
  output logic [PAY_W-1:0]           iss_payload,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  import cpu_pkg::*;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  rs_entry_t        q      [DEPTH];
  rs_entry_t        q_nxt  [DEPTH];
  rs_entry_t        woke   [DEPTH+1];  // extra top slot is the empty fill for compaction
  rs_entry_t        new_ent;
  rs_entry_t        stage;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] widx;
  logic [DEPTH-1:0] elig;
  logic             found;
  logic [IDX_W-1:0] sel;
  logic             load;
  logic             fire;

  // disp_ready only looks at registered occupancy, so a same-cycle stage
  // load never opens a slot for a dispatch at full.
  assign disp_ready = (occ < OCC_W'(DEPTH));
  assign fire       = disp_valid && disp_ready;
  assign load       = found && (!iss_valid || iss_ready);
  assign occupancy  = occ;

  assign iss_src1_tag = stage.src1_tag;
  assign iss_src2_tag = stage.src2_tag;
  assign iss_dst_tag  = stage.dst_tag;
  assign iss_payload  = stage.payload;

  // eligibility uses registered ready bits: a wakeup this cycle is seen next cycle
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      elig[i] = q[i].valid && q[i].src1_rdy && q[i].src2_rdy;
  end

  iss_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_sel (
    .elig  (elig),
    .found (found),
    .idx   (sel)
  );

  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.src1_tag = disp_src1_tag;
    new_ent.src2_tag = disp_src2_tag;
    new_ent.dst_tag  = disp_dst_tag;
    new_ent.payload  = disp_payload;
    // same-cycle broadcast bypass into the dispatching entry
    new_ent.src1_rdy = disp_src1_rdy || (wb_valid && disp_src1_tag == wb_tag);
    new_ent.src2_rdy = disp_src2_rdy || (wb_valid && disp_src2_tag == wb_tag);

    // dispatch lands just above the surviving entries
    widx = occ - OCC_W'(load);

    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = q[i];
      if (wb_valid && q[i].valid && q[i].src1_tag == wb_tag) woke[i].src1_rdy = 1'b1;
      if (wb_valid && q[i].valid && q[i].src2_tag == wb_tag) woke[i].src2_rdy = 1'b1;
    end
    woke[DEPTH] = '0;

    for (int i = 0; i < DEPTH; i++) begin
      if (load && i >= int'(sel)) q_nxt[i] = woke[i+1];
      else                        q_nxt[i] = woke[i];
      if (fire && widx == OCC_W'(i)) q_nxt[i] = new_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      occ       <= '0;
      stage     <= '0;
      iss_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
      occ <= occ + OCC_W'(fire) - OCC_W'(load);
      if (load) begin
        stage     <= q[sel];
        iss_valid <= 1'b1;
      end else if (iss_ready) begin
        iss_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Single-issue, in-order-age scheduler (reservation station) between the rename/dispatch stage and the ALU of the out-of-order CPU. Holds up to DEPTH dispatched instructions and wakes their source operands from completion-tag broadcasts. Each cycle it hands the oldest fully-ready instruction to the ALU through a registered valid/ready output stage. It is the sole arbiter of ALU issue slots.

## Interface
Parameters:
- DEPTH, 8, queue entries (power of two not required, ≥2)
- TAG_W, 6, physical-register tag width
- PAY_W, 47, opaque payload width (alu_sig 3 + imm 32 + pc 12)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all queued and staged instructions
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept (occupancy < DEPTH)
- disp_src1_tag, disp_src2_tag  in  TAG_W  source tags
- disp_src1_rdy, disp_src2_rdy  in  1  source already available at rename
- disp_dst_tag  in  TAG_W  destination tag
- disp_payload  in  PAY_W  carried unchanged to issue
- wb_valid  in  1  completion broadcast valid
- wb_tag  in  TAG_W  completing destination tag
- iss_valid  out  1  staged instruction present
- iss_ready  in  1  ALU accepts this cycle
- iss_src1_tag, iss_src2_tag, iss_dst_tag  out  TAG_W
- iss_payload  out  PAY_W
- occupancy  out  $clog2(DEPTH+1)  valid queue entries (excludes staged slot)

## Operation
- Queue is compacting: entry 0 oldest, valid entries contiguous from 0.
- Dispatch accepted when disp_valid && disp_ready; written at index occupancy (post-removal index if an entry leaves same cycle).
- Wakeup: wb_valid && tag match sets that source's rdy bit in every valid entry. Dispatch with a source tag equal to same-cycle wb_tag is written with rdy=1 (bypass).
- Entry eligible when both rdy bits set. Select = lowest-index eligible entry (iss_select).
- Stage load: if !iss_valid || iss_ready, and an eligible entry exists, it moves into the output register; entries above shift down one.
- Output register holds stable while iss_valid && !iss_ready.
- disp_ready derives from registered occupancy only; a same-cycle removal does not raise it.
- flush: next cycle occupancy=0, iss_valid=0; any dispatch that cycle is dropped; ALU handshake that cycle is ignored.
- wb for a tag not present or already ready: no effect.

## Timing
- Reset (and flush) values: iss_valid 0, all iss_* fields 0, occupancy 0, disp_ready 1, all entries invalid.
- Rst mid-operation: all state cleared on that edge, rst dominates flush and dispatch.
- Dispatch in cycle N with both sources ready → eligible in N+1 → iss_valid in N+2 (min latency 2).
- wb in cycle N → entry eligible N+1 → earliest iss_valid N+2. No same-cycle wakeup-to-select.
- Back-to-back issue: one instruction per cycle when iss_ready held high and eligible entries exist.
- Full: occupancy==DEPTH ⇒ disp_ready=0; dispatch+issue in same cycle at full is not allowed (disp_ready already 0).
- Occupancy updates: +1 dispatch, −1 stage load, both ⇒ unchanged.

## Structure
- Shared package cpu_pkg: TAG_W, PAY_W constants; rs_entry_t typedef {valid, src1_tag, src1_rdy, src2_tag, src2_rdy, dst_tag, payload}.
- Sub-module iss_select: DEPTH-bit eligible vector → found flag + lowest index; purely combinational.
- Top holds entry array, wakeup compare, compaction shift, output register, occupancy counter.

## Test plan
- Reset then dispatch tag dst=5, both rdy=1, iss_ready=1 → iss_valid high exactly 2 cycles later with dst 5, payload unchanged; occupancy returns to 0.
- Dispatch A(src1=7 not ready), then B(ready) → B issues first; wb_tag=7 at cycle 10 → A iss_valid at cycle 12.
- Fill 8 entries with unready sources → disp_ready=0, occupancy=8; extra disp_valid ignored; wb frees all → 8 issues on consecutive cycles, oldest first.
- Hold iss_ready=0 for 4 cycles with staged instruction → iss_* fields constant, no entry lost; release → next oldest follows next cycle.
- Dispatch src2=9 in same cycle as wb_tag=9 → entry written ready, issues at N+2.
- Flush with 5 queued + 1 staged, concurrent disp_valid → next cycle iss_valid=0, occupancy=0, disp_ready=1; subsequent wb issues nothing.
